// File: rtl/butterfly_injector.sv
`default_nettype none
// ============================================================================
// Module      : butterfly_injector
// Description : Endpoint-side injection FIFO that formats payloads into
//               butterfly network packets and presents them to a level-0 node.
// Revision    : 1.0 - initial release
// ============================================================================
module butterfly_injector #(
    parameter logic [3:0] SRC_ID = 4'd0,
    parameter int         DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_data,
    input  logic [3:0]  in_dest,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [40:0] out_packet,
    output logic        out_channel,
    output logic [3:0]  fill,
    output logic [15:0] sent_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Storage holds {data, dest}; source and level are constant and added on read.
    logic [33:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    fill_next;
    logic [33:0]   head;
    logic          push;
    logic          pop;

    assign in_ready  = (fill < 4'(DEPTH)) && !rst;
    assign out_valid = (fill != 4'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign fill_next = fill + {3'b000, push} - {3'b000, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            fill     <= 4'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sent_cnt <= 16'd0;
        end else begin
            fill <= fill_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                sent_cnt <= sent_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data, in_dest};
        end
    end

    // Output comes only from stored head state, so no in_* to out_* path exists.
    assign head        = mem[rd_ptr];
    assign out_packet  = out_valid ? {head[33:4], SRC_ID, head[3:0], 3'd0} : 41'd0;
    assign out_channel = out_valid & (SRC_ID[0] ^ head[0]);

endmodule
`default_nettype wire

// File: tb/tb_butterfly_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_butterfly_injector
// Description : Scoreboard-based self-checking bench for butterfly_injector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_butterfly_injector;

    localparam logic [3:0] SRC = 4'h5;
    localparam int         DEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_data = '0;
    logic [3:0]  in_dest = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [40:0] out_packet;
    logic        out_channel;
    logic [3:0]  fill;
    logic [15:0] sent_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries are {channel, packet}.
    logic [41:0] sb_q[$];
    int          m_fill = 0;
    logic [15:0] m_sent = 16'd0;

    butterfly_injector #(.SRC_ID(SRC), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .out_channel(out_channel),
        .fill       (fill),
        .sent_cnt   (sent_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: inputs only change 1 time unit after a rising edge, so values seen
    // on the falling edge are exactly those the next rising edge will sample.
    always @(negedge clk) begin
        logic [41:0] exp_e;
        logic        do_push;
        logic        do_pop;
        if (rst) begin
            n_checks++;
            if (in_ready !== 1'b0)
                $display("FAIL rst_in_ready: got %b expected 0", in_ready);
            else n_pass++;
            sb_q.delete();
            m_fill = 0;
            m_sent = 16'd0;
        end else begin
            n_checks++;
            if (in_ready !== (m_fill < DEP))
                $display("FAIL mon_in_ready: got %b expected %b", in_ready, (m_fill < DEP));
            else n_pass++;
            n_checks++;
            if (out_valid !== (m_fill != 0))
                $display("FAIL mon_out_valid: got %b expected %b", out_valid, (m_fill != 0));
            else n_pass++;
            n_checks++;
            if (fill !== 4'(m_fill))
                $display("FAIL mon_fill: got %0d expected %0d", fill, m_fill);
            else n_pass++;
            n_checks++;
            if (sent_cnt !== m_sent)
                $display("FAIL mon_sent_cnt: got %0d expected %0d", sent_cnt, m_sent);
            else n_pass++;
            if (m_fill != 0) begin
                n_checks++;
                if ({out_channel, out_packet} !== sb_q[0])
                    $display("FAIL mon_head: got ch=%b pkt=%h expected ch=%b pkt=%h",
                             out_channel, out_packet, sb_q[0][41], sb_q[0][40:0]);
                else n_pass++;
            end else begin
                n_checks++;
                if (out_packet !== 41'd0)
                    $display("FAIL mon_idle_pkt: got %h expected 0", out_packet);
                else n_pass++;
            end
            do_pop  = (m_fill != 0) && out_ready;
            do_push = in_valid && (m_fill < DEP);
            if (do_pop) begin
                void'(sb_q.pop_front());
                m_fill--;
                m_sent = m_sent + 16'd1;
            end
            if (do_push) begin
                exp_e = {SRC[0] ^ in_dest[0], in_data, SRC, in_dest, 3'd0};
                sb_q.push_back(exp_e);
                m_fill++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic r, input logic [29:0] d, input logic [3:0] dst);
        in_valid = v; out_ready = r; in_data = d; in_dest = dst;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (fill !== 4'd0 || out_valid !== 1'b0 || sent_cnt !== 16'd0 || in_ready !== 1'b0)
            $display("FAIL reset_state: got fill=%0d ov=%b sent=%0d ir=%b expected 0/0/0/0",
                     fill, out_valid, sent_cnt, in_ready);
        else n_pass++;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 30'h1234567, 4'hA);
        tick();
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_packet !== {30'h1234567, 4'h5, 4'hA, 3'd0} || out_channel !== 1'b1)
            $display("FAIL basic_packet: got ov=%b pkt=%h ch=%b expected 1 %h 1",
                     out_valid, out_packet, out_channel, {30'h1234567, 4'h5, 4'hA, 3'd0});
        else n_pass++;
        tick();
        n_checks++;
        if (sent_cnt !== 16'd1 || fill !== 4'd0)
            $display("FAIL basic_sent: got sent=%0d fill=%0d expected 1 0", sent_cnt, fill);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 30'(32'h100 + i), 4'(i + 2));
            tick();
            n_checks++;
            if (fill !== 4'((i < 4) ? i + 1 : 4))
                $display("FAIL full_fill_%0d: got %0d expected %0d", i, fill, (i < 4) ? i + 1 : 4);
            else n_pass++;
        end
        n_checks++;
        if (in_ready !== 1'b0)
            $display("FAIL full_in_ready: got %b expected 0", in_ready);
        else n_pass++;
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (fill !== 4'd0 || sent_cnt !== 16'd4)
            $display("FAIL full_drain: got fill=%0d sent=%0d expected 0 4", fill, sent_cnt);
        else n_pass++;
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 30'(32'h2000 + i), 4'(i));
            tick();
        end
        drive(1'b1, 1'b1, 30'h2abc, 4'h7);
        tick();
        n_checks++;
        if (fill !== 4'd3 || in_ready !== 1'b1)
            $display("FAIL fullpp_pop_only: got fill=%0d ir=%b expected 3 1", fill, in_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (fill !== 4'd3 || sent_cnt !== 16'd2)
            $display("FAIL fullpp_accept: got fill=%0d sent=%0d expected 3 2", fill, sent_cnt);
        else n_pass++;
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_stream();
        do_reset();
        drive(1'b1, 1'b0, 30'h3000, 4'h1);
        tick();
        drive(1'b1, 1'b0, 30'h3001, 4'h5);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 30'($urandom), 4'($urandom_range(0, 15)));
            tick();
            n_checks++;
            if (fill !== 4'd2)
                $display("FAIL stream_fill_%0d: got %0d expected 2", i, fill);
            else n_pass++;
        end
        n_checks++;
        if (sent_cnt !== 16'd20)
            $display("FAIL stream_sent: got %0d expected 20", sent_cnt);
        else n_pass++;
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        tick();
        tick();
    endtask

    task automatic test_self_dest();
        drive(1'b1, 1'b0, 30'h0ABCDEF, SRC);
        tick();
        drive(1'b0, 1'b0, 30'h0, 4'h0);
        #1;
        n_checks++;
        if (out_channel !== 1'b0 || out_packet !== {30'h0ABCDEF, 4'h5, 4'h5, 3'd0})
            $display("FAIL self_dest: got ch=%b pkt=%h expected 0 %h",
                     out_channel, out_packet, {30'h0ABCDEF, 4'h5, 4'h5, 3'd0});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (out_packet !== {30'h0ABCDEF, 4'h5, 4'h5, 3'd0})
            $display("FAIL stall_hold: got %h expected %h", out_packet, {30'h0ABCDEF, 4'h5, 4'h5, 3'd0});
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 30'(32'h5000 + i), 4'(i + 8));
            tick();
        end
        drive(1'b0, 1'b0, 30'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || fill !== 4'd0 || sent_cnt !== 16'd0)
            $display("FAIL midrst_state: got ov=%b fill=%0d sent=%0d expected 0 0 0",
                     out_valid, fill, sent_cnt);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (out_valid !== 1'b0 || sent_cnt !== 16'd0)
            $display("FAIL midrst_stale: got ov=%b sent=%0d expected 0 0", out_valid, sent_cnt);
        else n_pass++;
        drive(1'b1, 1'b1, 30'h6006, 4'hC);
        tick();
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 30'h7000, 4'h3);
        tick();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b1, 1'b1, 30'($urandom), 4'($urandom_range(0, 15)));
            tick();
        end
        n_checks++;
        if (sent_cnt !== 16'd0 || fill !== 4'd1)
            $display("FAIL wrap_zero: got sent=%0d fill=%0d expected 0 1", sent_cnt, fill);
        else n_pass++;
        drive(1'b0, 1'b1, 30'h0, 4'h0);
        tick();
        n_checks++;
        if (sent_cnt !== 16'd1 || fill !== 4'd0)
            $display("FAIL wrap_one: got sent=%0d fill=%0d expected 1 0", sent_cnt, fill);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_full_pushpop();
        test_stream();
        test_self_dest();
        test_reset_mid();
        test_wrap();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/butterfly_injector.md
BUTTERFLY_INJECTOR -- requirements
Module: butterfly_injector

Interface
REQ-001 Parameter: SRC_ID, default 4'd0, 4-bit network address of the attached endpoint; written into every packet's source field.
REQ-002 Parameter: DEPTH, default 4, FIFO entry count; legal values 2, 4, 8.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  endpoint offers a payload.
REQ-006 Port: in_ready  output  1  injector accepts a payload this cycle.
REQ-007 Port: in_data  input  30  payload data.
REQ-008 Port: in_dest  input  4  destination address.
REQ-009 Port: out_valid  output  1  head packet presented to the first-level butterfly node.
REQ-010 Port: out_ready  input  1  first-level node accepts the packet this cycle.
REQ-011 Port: out_packet  output  41  formatted packet.
REQ-012 Port: out_channel  output  1  first-hop direction of the head packet.
REQ-013 Port: fill  output  4  current FIFO occupancy, 0..DEPTH.
REQ-014 Port: sent_cnt  output  16  count of completed output transfers.

Function
REQ-015 Packet format SHALL be [40:11] data, [10:7] source = SRC_ID, [6:3] destination = in_dest, [2:0] level = 3'd0.
REQ-016 out_channel SHALL equal bit 0 of (SRC_ID XOR head destination), matching the level-0 routing decision of a butterfly node.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 exactly when fill < DEPTH, and SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL be 1 exactly when fill != 0.
REQ-020 out_packet and out_channel SHALL be driven only from registered FIFO head state, with no combinational path from in_* ports.
REQ-021 Latency: a payload accepted at edge N into an empty FIFO SHALL appear on out_packet with out_valid=1 in the cycle following edge N.
REQ-022 Ordering SHALL be strict FIFO; no packet SHALL be dropped, duplicated or reordered.
REQ-023 While out_valid=1 and out_ready=0, out_packet and out_channel SHALL hold stable.
REQ-024 Push only: fill SHALL increment by 1. Pop only: fill SHALL decrement by 1. Simultaneous push and pop with 0 < fill < DEPTH: fill SHALL be unchanged.
REQ-025 When full: in_ready=0, so no push SHALL occur even if a pop occurs in the same cycle; fill SHALL become DEPTH-1.
REQ-026 When empty: no pop SHALL occur, and a push SHALL NOT bypass to the output in the same cycle.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 sent_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 16'hFFFF to 0.
REQ-029 A packet with in_dest == SRC_ID SHALL be injected normally, with out_channel=0.

Reset
REQ-030 While rst=1 at a rising edge: fill=0, pointers=0, sent_cnt=0, out_valid=0, in_ready=0.
REQ-031 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered packets; FIFO storage contents need not be cleared.
REQ-033 out_packet SHALL read 41'd0 while out_valid=0.

Verification
REQ-034 SRC_ID=4'h5: push data=30'h1234567, dest=4'hA with out_ready=1 -> next cycle out_packet={30'h1234567,4'h5,4'hA,3'd0}, out_channel=1, then sent_cnt=1.
REQ-035 out_ready=0, 5 pushes at DEPTH=4 -> in_ready=0 after 4th, fill=4, 5th not accepted; then out_ready=1 -> 4 packets drain in push order.
REQ-036 Full FIFO, in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, fill=3; next cycle the push is accepted.
REQ-037 Continuous push and pop for 20 cycles -> fill constant, pointer wrap exercised, sent_cnt=20, order preserved.
REQ-038 Three packets buffered, rst pulsed for 1 cycle -> out_valid=0, fill=0, sent_cnt=0; the stale packets never appear.
REQ-039 sent_cnt preloaded via 65536 transfers -> sent_cnt reads 0 and the next transfer gives 1.
